// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
//
// Bundles the requester-side command/response handshake and the APB4 bus
// driven by apb_master_bridge.
//
//   master modport : the bridge's view (drives cmd_ready, rsp_*, P* outputs)
//   slave  modport : the environment's view (requester plus APB completer)
//
// Signals:
//   cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA  (bridge -> completer)
//   PRDATA, PREADY, PSLVERR                             (completer -> bridge)

interface apb_master_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);

   // command channel
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic                      cmd_write;
   logic [ADDR_WIDTH-1:0]     cmd_addr;
   logic [DATA_WIDTH-1:0]     cmd_wdata;
   logic [DATA_WIDTH/8-1:0]   cmd_strb;
   logic [2:0]                cmd_prot;

   // response channel
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_WIDTH-1:0]     rsp_rdata;
   logic                      rsp_err;

   // APB4 bus
   logic                      PSEL;
   logic                      PENABLE;
   logic                      PWRITE;
   logic [2:0]                PPROT;
   logic [DATA_WIDTH/8-1:0]   PSTRB;
   logic [ADDR_WIDTH-1:0]     PADDR;
   logic [DATA_WIDTH-1:0]     PWDATA;
   logic [DATA_WIDTH-1:0]     PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      input  rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      output rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA
   );

endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//
// Turns a valid/ready command into a single APB4 transfer and returns one
// response (read data + error) per transfer. One transfer in flight at a time;
// the FSM walks IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//
// Ports:
//   PCLK    : clock, all state updates on the rising edge
//   PRESET  : synchronous active-high reset
//   bus     : apb_master_bridge_if.master (command, response and APB signals)
//
// Every output except cmd_ready is a flop. cmd_ready is (state == IDLE) && !PRESET.
// Address/control/data on the APB side hold their last values while PSEL=0.
//
// Build option:
//   APB_TIMEOUT_EN : when defined, an ACCESS phase that sees PREADY=0 for
//                    TIMEOUT_CYCLES consecutive cycles is aborted and answered
//                    with rsp_err=1, rsp_rdata=0. When undefined, ACCESS waits
//                    indefinitely for PREADY.

module apb_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                 PCLK,
   input logic                 PRESET,
   apb_master_bridge_if.master bus
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;

   // Reject unsupported configurations at elaboration.
   if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : gen_bad_data_width
      $error("apb_master_bridge: DATA_WIDTH must be 8, 16 or 32");
   end
   if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } state_e;

   state_e                 state_q, state_d;
   logic                   psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   pwrite_q, pwrite_d;
   logic [2:0]             pprot_q, pprot_d;
   logic [StrbWidth-1:0]   pstrb_q, pstrb_d;
   logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   cmd_ready;
   logic                   timeout;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Counts ACCESS cycles seen with PREADY=0; cleared on entry to ACCESS.
   logic [CntWidth-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign cmd_ready = (state_q == StIdle) && !PRESET;

   // Next-state and output-register logic.
   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pprot_d     = pprot_q;
      pstrb_d     = pstrb_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid && cmd_ready) begin
               state_d   = StSetup;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               paddr_d   = bus.cmd_addr;
               pwrite_d  = bus.cmd_write;
               pprot_d   = bus.cmd_prot;
               // Reads drive zero strobes and zero write data.
               pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
               pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
            end
         end

         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end

         StAccess: begin
            if (bus.PREADY) begin
               state_d     = StResp;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = bus.PSLVERR;
               rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
            end else if (timeout) begin
               state_d     = StResp;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
`ifdef APB_TIMEOUT_EN
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end

         StResp: begin
            if (bus.rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= StIdle;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pprot_q     <= '0;
         pstrb_q     <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pprot_q     <= pprot_d;
         pstrb_q     <= pstrb_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PPROT     = pprot_q;
   assign bus.PSTRB     = pstrb_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge: zero-wait write, waited read, slave
// error with response back-pressure, reset during ACCESS, back-to-back
// traffic and the ACCESS timeout (or its absence when APB_TIMEOUT_EN is not
// defined). A negedge monitor flags PSEL=0 with PENABLE=1.

module tb_apb_master_bridge;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic pclk;
   logic preset;
   int   n_vec;
   int   n_err;

   apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master_bridge #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .PCLK   (pclk),
      .PRESET (preset),
      .bus    (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_strb  = strb;
      bus.cmd_prot  = prot;
   endtask

   always @(negedge pclk) begin
      check_eq("psel0_penable1", {63'd0, (!bus.PSEL && bus.PENABLE)}, 64'd0);
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      preset        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_strb  = '0;
      bus.cmd_prot  = '0;
      bus.rsp_ready = 1'b0;
      bus.PRDATA    = '0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check_eq("rst_psel",      bus.PSEL,      0);
      check_eq("rst_penable",   bus.PENABLE,   0);
      check_eq("rst_paddr",     bus.PADDR,     0);
      check_eq("rst_pstrb",     bus.PSTRB,     0);
      check_eq("rst_rsp_valid", bus.rsp_valid, 0);
      check_eq("rst_cmd_ready", bus.cmd_ready, 0);
      preset = 1'b0;
      #1;
      check_eq("idle_cmd_ready", bus.cmd_ready, 1);

      // ---------------- zero-wait write ----------------
      set_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
      bus.PREADY = 1'b1;
      tick();                                   // accept edge -> SETUP
      check_eq("wr_setup_psel",    bus.PSEL,    1);
      check_eq("wr_setup_penable", bus.PENABLE, 0);
      check_eq("wr_setup_paddr",   bus.PADDR,   32'h10);
      check_eq("wr_setup_pwrite",  bus.PWRITE,  1);
      check_eq("wr_setup_pwdata",  bus.PWDATA,  32'hDEADBEEF);
      check_eq("wr_setup_pstrb",   bus.PSTRB,   4'hF);
      check_eq("wr_setup_pprot",   bus.PPROT,   3'b010);
      check_eq("wr_setup_cmdrdy",  bus.cmd_ready, 0);
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 32'hFFFF_FFFF;            // must not leak into the transfer
      bus.cmd_wdata = 32'h0;
      tick();                                   // ACCESS
      check_eq("wr_acc_psel",    bus.PSEL,    1);
      check_eq("wr_acc_penable", bus.PENABLE, 1);
      check_eq("wr_acc_paddr",   bus.PADDR,   32'h10);
      check_eq("wr_acc_pwdata",  bus.PWDATA,  32'hDEADBEEF);
      tick();                                   // RESP (N+3)
      check_eq("wr_rsp_valid", bus.rsp_valid, 1);
      check_eq("wr_rsp_err",   bus.rsp_err,   0);
      check_eq("wr_rsp_rdata", bus.rsp_rdata, 0);
      check_eq("wr_rsp_psel",  bus.PSEL,      0);
      check_eq("wr_hold_paddr", bus.PADDR,    32'h10);
      bus.rsp_ready = 1'b1;
      tick();
      check_eq("wr_done_valid",  bus.rsp_valid, 0);
      check_eq("wr_done_cmdrdy", bus.cmd_ready, 1);
      bus.rsp_ready = 1'b0;

      // ---------------- read, 3 wait states ----------------
      set_cmd(1'b0, 32'h24, 32'hAAAA_AAAA, 4'hF, 3'b000);
      bus.PREADY  = 1'b0;
      bus.PRDATA  = 32'h0BAD_0BAD;              // ignored while PREADY=0
      bus.PSLVERR = 1'b1;
      tick();                                   // SETUP
      check_eq("rd_setup_pstrb",  bus.PSTRB,  0);
      check_eq("rd_setup_pwdata", bus.PWDATA, 0);
      check_eq("rd_setup_pwrite", bus.PWRITE, 0);
      check_eq("rd_setup_paddr",  bus.PADDR,  32'h24);
      bus.cmd_valid = 1'b0;
      tick();                                   // ACCESS 1
      for (int i = 0; i < 3; i++) begin
         check_eq("rd_wait_psel",    bus.PSEL,      1);
         check_eq("rd_wait_penable", bus.PENABLE,   1);
         check_eq("rd_wait_paddr",   bus.PADDR,     32'h24);
         check_eq("rd_wait_pstrb",   bus.PSTRB,     0);
         check_eq("rd_wait_rvalid",  bus.rsp_valid, 0);
         tick();
      end
      // ACCESS 4
      check_eq("rd_acc4_penable", bus.PENABLE, 1);
      check_eq("rd_acc4_paddr",   bus.PADDR,   32'h24);
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b0;
      bus.PRDATA  = 32'h12345678;
      tick();                                   // RESP (N+6)
      check_eq("rd_rsp_valid", bus.rsp_valid, 1);
      check_eq("rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
      check_eq("rd_rsp_err",   bus.rsp_err,   0);
      check_eq("rd_rsp_psel",  bus.PSEL,      0);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;

      // ---------------- slave error, rsp back-pressure ----------------
      set_cmd(1'b1, 32'h30, 32'h0000_0055, 4'h1, 3'b001);
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b1;
      bus.PRDATA  = 32'h7777_7777;
      tick();                                   // SETUP
      bus.cmd_valid = 1'b0;
      tick();                                   // ACCESS
      tick();                                   // RESP
      bus.PSLVERR = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_eq("err_rsp_valid", bus.rsp_valid, 1);
         check_eq("err_rsp_err",   bus.rsp_err,   1);
         check_eq("err_rsp_rdata", bus.rsp_rdata, 0);
         check_eq("err_cmd_ready", bus.cmd_ready, 0);
         tick();
      end
      check_eq("err_still_valid", bus.rsp_valid, 1);
      bus.rsp_ready = 1'b1;
      #1;
      check_eq("err_accept_cmdrdy", bus.cmd_ready, 0);
      tick();
      check_eq("err_after_valid",  bus.rsp_valid, 0);
      check_eq("err_after_cmdrdy", bus.cmd_ready, 1);
      bus.rsp_ready = 1'b0;

      // ---------------- reset during ACCESS wait ----------------
      set_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
      bus.PREADY = 1'b0;
      tick();                                   // SETUP
      bus.cmd_valid = 1'b0;
      tick();                                   // ACCESS 1
      tick();                                   // ACCESS 2
      check_eq("mrst_pre_penable", bus.PENABLE, 1);
      preset = 1'b1;
      #1;
      check_eq("mrst_cmdrdy_in_rst", bus.cmd_ready, 0);
      tick();
      check_eq("mrst_psel",      bus.PSEL,      0);
      check_eq("mrst_penable",   bus.PENABLE,   0);
      check_eq("mrst_rsp_valid", bus.rsp_valid, 0);
      check_eq("mrst_paddr",     bus.PADDR,     0);
      preset = 1'b0;
      #1;
      check_eq("mrst_cmd_ready", bus.cmd_ready, 1);
      bus.PREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("mrst_no_rsp",  bus.rsp_valid, 0);
         check_eq("mrst_no_psel", bus.PSEL,      0);
      end

      // ---------------- back-to-back, zero wait ----------------
      bus.rsp_ready = 1'b1;
      bus.PREADY    = 1'b1;
      bus.PSLVERR   = 1'b0;
      set_cmd(1'b1, 32'h100, 32'hC0DE_0000, 4'hF, 3'b000);
      for (int cyc = 0; cyc < 16; cyc++) begin
         bus.cmd_addr  = 32'h100 + cyc;
         bus.cmd_wdata = 32'hC0DE_0000 + cyc;
         #1;
         check_eq("b2b_cmd_ready", bus.cmd_ready, (cyc % 4) == 0);
         if ((cyc % 4) == 1) begin
            check_eq("b2b_setup_paddr",  bus.PADDR,  32'h100 + cyc - 1);
            check_eq("b2b_setup_pwdata", bus.PWDATA, 32'hC0DE_0000 + cyc - 1);
         end
         check_eq("b2b_rsp_valid", bus.rsp_valid, (cyc % 4) == 3);
         tick();
      end
      bus.cmd_valid = 1'b0;
      #1;
      check_eq("b2b_end_cmdrdy", bus.cmd_ready, 1);
      bus.rsp_ready = 1'b0;

      // ---------------- ACCESS timeout ----------------
      set_cmd(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h0000_0099;
      tick();                                   // SETUP
      bus.cmd_valid = 1'b0;
      tick();                                   // ACCESS 1
`ifdef APB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         check_eq("to_wait_psel",   bus.PSEL,      1);
         check_eq("to_wait_rvalid", bus.rsp_valid, 0);
         tick();
      end
      check_eq("to_rsp_valid", bus.rsp_valid, 1);
      check_eq("to_rsp_err",   bus.rsp_err,   1);
      check_eq("to_rsp_rdata", bus.rsp_rdata, 0);
      check_eq("to_psel",      bus.PSEL,      0);
      check_eq("to_penable",   bus.PENABLE,   0);
`else
      for (int i = 0; i < 20; i++) begin
         check_eq("noto_psel",    bus.PSEL,      1);
         check_eq("noto_penable", bus.PENABLE,   1);
         check_eq("noto_rvalid",  bus.rsp_valid, 0);
         tick();
      end
      bus.PREADY = 1'b1;
      tick();
      check_eq("noto_rsp_valid", bus.rsp_valid, 1);
      check_eq("noto_rsp_err",   bus.rsp_err,   0);
      check_eq("noto_rsp_rdata", bus.rsp_rdata, 32'h0000_0099);
`endif
      bus.rsp_ready = 1'b1;
      tick();
      check_eq("to_done_valid",  bus.rsp_valid, 0);
      check_eq("to_done_cmdrdy", bus.cmd_ready, 1);
      bus.rsp_ready = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command/response interface into APB4 master transfers on the team's APB bus (PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA out; PRDATA, PREADY, PSLVERR in).
- Sits directly upstream of the APB interface and is its only driver. One transfer is outstanding at a time.
- Each completed transfer returns one response (read data and error) to the requester.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort (used only with APB_TIMEOUT_EN); must be >= 2

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  PSLVERR captured, or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PPROT  out  3  APB protection
- PSTRB  out  DATA_WIDTH/8  APB strobes
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1 each  APB completion and error

Behaviour:
- Clock and reset: one clock, PCLK. Reset is PRESET, synchronous and active-high.
- Output registers: all outputs except cmd_ready are registered. cmd_ready = (state == IDLE) && !PRESET.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PPROT=0, PSTRB=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, capture the command. Next cycle is SETUP.
  - SETUP outputs: PSEL=1, PENABLE=0, PADDR/PWRITE/PPROT driven from the captured command.
  - Writes: PWDATA=cmd_wdata, PSTRB=cmd_strb.
  - Reads: PSTRB=0, PWDATA=0.
- SETUP: always moves to ACCESS after one cycle, PENABLE=1. Address, control and data are held stable.
- ACCESS: PREADY is sampled every cycle.
  - PREADY=0: stay in ACCESS, all APB outputs unchanged.
  - PREADY=1: next cycle PSEL=0, PENABLE=0, and the state goes to RESP.
  - At that same edge: rsp_valid=1, rsp_err=PSLVERR, rsp_rdata = PRDATA for reads, 0 for writes.
  - PSLVERR and PRDATA are ignored whenever PREADY=0.
- Idle bus values: PADDR, PWRITE, PPROT, PSTRB and PWDATA hold their last values when PSEL=0, except that reset clears them.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On acceptance: rsp_valid=0 and the state goes to IDLE. The next command can be accepted in the following cycle.
- Latency: zero-wait-state slave gives command accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3. Each slave wait state adds 1 cycle.
- Back-to-back throughput: at most one transfer per 4 cycles with zero wait states and rsp_ready tied high.
- Command stability: cmd_* signals are sampled only on the accept cycle. Later changes have no effect.
- Reset mid-transfer: PRESET in any state returns to reset values at the next edge. PSEL drops immediately (protocol abort is accepted by the system). Any pending response is discarded.
- Bus state constraint: PSEL=0 && PENABLE=1 never occurs.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - If the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0, the next edge forces PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, and the state goes to RESP.
  - If PREADY=1 on the final counted cycle, that is a normal completion.
- Not defined: no counter exists, and ACCESS waits indefinitely for PREADY.

Test Plan:
- Zero-wait write:
  - Stimulus: cmd addr=0x10, wdata=0xDEADBEEF, strb=0xF, prot=3'b010, PREADY=1.
  - Response: SETUP one cycle later, ACCESS the cycle after, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: addr=0x24, PREADY low for 3 ACCESS cycles, then PRDATA=0x12345678.
  - Response: PSTRB=0 throughout, APB signals stable for 4 ACCESS cycles, rsp_rdata=0x12345678 at N+6.
- Slave error with back-pressure:
  - Stimulus: write completes with PSLVERR=1, rsp_ready held low 5 cycles.
  - Response: rsp_err=1 and rsp_valid held stable for 5 cycles; cmd_ready=0 until acceptance, then 1 the next cycle.
- Reset mid-transfer:
  - Stimulus: PRESET=1 during an ACCESS wait state.
  - Response: next cycle PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1 once PRESET deasserts; no response is issued.
- Back-to-back traffic:
  - Stimulus: 4 commands with cmd_valid held high and rsp_ready=1, zero wait states.
  - Response: commands accepted at cycles 0, 4, 8, 12; PSEL/PENABLE never 0/1.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: PREADY held 0.
  - Response: after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL=0.
  - Without the macro: still in ACCESS after 20 cycles.
